// File: rtl/float2uchar_pkg.sv
// rtl/float2uchar_pkg.sv - shared float<->uchar constants, state and class encodings
package float2uchar_pkg;

    localparam int FLT_BIAS = 127;
    localparam int FLT_E_W  = 8;
    localparam int FLT_F_W  = 23;
    localparam int ACC_W    = FLT_F_W + 1;
    localparam int CNT_W    = 5;

    localparam logic [7:0] UCHAR_MAX = 8'd255;

    localparam logic [FLT_E_W-1:0] E_MAX      = '1;
    localparam logic [FLT_E_W-1:0] E_HALF_MAX = FLT_E_W'(FLT_BIAS - 2);
    localparam logic [FLT_E_W-1:0] E_OVF      = FLT_E_W'(FLT_BIAS + 8);
    localparam logic [FLT_E_W-1:0] SHIFT_BASE = FLT_E_W'(FLT_BIAS + FLT_F_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CLS_ZERO    = 3'd0,
        CLS_NAN     = 3'd1,
        CLS_POS_SAT = 3'd2,
        CLS_NEG_SAT = 3'd3,
        CLS_NORMAL  = 3'd4
    } cls_t;

endpackage

// File: rtl/float2uchar_classify.sv
// rtl/float2uchar_classify.sv - sorts a float into special cases and sets the initial shift count
module float2uchar_classify
    import float2uchar_pkg::*;
(
    input  logic               S,
    input  logic [FLT_E_W-1:0] E,
    input  logic [FLT_F_W-1:0] F,
    output cls_t               cls,
    output logic [CNT_W-1:0]   shift_cnt
);

    always_comb begin
        cls       = CLS_ZERO;
        // Only meaningful for CLS_NORMAL, where E is 126..134 and the count is 16..24.
        shift_cnt = CNT_W'(SHIFT_BASE - E);
        if (E == E_MAX) begin
            if (F != '0)
                cls = CLS_NAN;
            else
                cls = S ? CLS_NEG_SAT : CLS_POS_SAT;
        end else if (E == '0) begin
            cls = CLS_ZERO;
        end else if (S) begin
            cls = CLS_NEG_SAT;
        end else if (E <= E_HALF_MAX) begin
            cls = CLS_ZERO;
        end else if (E >= E_OVF) begin
            cls = CLS_POS_SAT;
        end else begin
            cls = CLS_NORMAL;
        end
    end

endmodule

// File: rtl/float2uchar.sv
// rtl/float2uchar.sv - multi-cycle IEEE-754 single to rounded, clamped 8-bit unsigned converter
module float2uchar
    import float2uchar_pkg::*;
#(
    parameter int ROUND_NEAREST = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               S,
    input  logic [FLT_E_W-1:0] E,
    input  logic [FLT_F_W-1:0] F,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         D,
    output logic               sat,
    output logic               nan
);

    state_t             state, state_nxt;
    cls_t               cls;
    logic [CNT_W-1:0]   shift_cnt;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   acc;
    logic               guard, sticky;
    logic               inc;
    logic [8:0]         rsum;
    logic               accept;

    float2uchar_classify u_classify (
        .S         (S),
        .E         (E),
        .F         (F),
        .cls       (cls),
        .shift_cnt (shift_cnt)
    );

    assign accept = in_valid && (state == ST_IDLE);
    assign inc    = (ROUND_NEAREST != 0) && guard && (sticky || acc[0]);
    assign rsum   = {1'b0, acc[7:0]} + {8'd0, inc};

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (in_valid) state_nxt = (cls == CLS_NORMAL) ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (cnt == CNT_W'(1)) state_nxt = ST_ROUND;
            ST_ROUND: state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            guard  <= 1'b0;
            sticky <= 1'b0;
            cnt    <= '0;
            D      <= '0;
            sat    <= 1'b0;
            nan    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (cls)
                            CLS_NAN: begin
                                D <= '0; sat <= 1'b0; nan <= 1'b1;
                            end
                            CLS_POS_SAT: begin
                                D <= UCHAR_MAX; sat <= 1'b1; nan <= 1'b0;
                            end
                            CLS_NEG_SAT: begin
                                D <= '0; sat <= 1'b1; nan <= 1'b0;
                            end
                            CLS_NORMAL: begin
                                acc    <= {1'b1, F};
                                guard  <= 1'b0;
                                sticky <= 1'b0;
                                cnt    <= shift_cnt;
                            end
                            default: begin
                                D <= '0; sat <= 1'b0; nan <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_SHIFT: begin
                    sticky <= sticky | guard;
                    guard  <= acc[0];
                    acc    <= acc >> 1;
                    cnt    <= cnt - CNT_W'(1);
                end
                ST_ROUND: begin
                    // A carry out of bit 7 means rounding pushed 255.x past the byte range.
                    if (rsum[8]) begin
                        D   <= UCHAR_MAX;
                        sat <= 1'b1;
                    end else begin
                        D   <= rsum[7:0];
                        sat <= 1'b0;
                    end
                    nan <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
